// File: rtl/controlador_soma_serial.sv
// Serial wide adder/subtractor: one shared 4-bit ripple adder walks the operands
// a nibble per cycle, LSB first, chaining the carry through a register.

module somador_4bits (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_soma,
    output logic       o_cout
);
    logic [4:0] w_c;

    assign w_c[0] = i_cin;

    // Four chained full adders.
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign o_soma[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_c[4];
endmodule

module controlador_soma_serial #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inicio,
    input  logic                   sub,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [4*NIBBLES-1:0]   soma,
    output logic                   carry_out,
    output logic                   overflow
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        SOMANDO   = 2'd1,
        CONCLUIDO = 2'd2
    } estado_t;

    estado_t            r_estado;
    estado_t            w_prox_estado;

    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_soma;
    logic               r_carry_out;
    logic               r_overflow;
    logic               r_ocupado;
    logic               r_pronto;

    logic [W-1:0]       w_a_prox;
    logic [W-1:0]       w_b_prox;
    logic               w_carry_prox;
    logic [IDX_W-1:0]   w_idx_prox;
    logic [W-1:0]       w_soma_prox;
    logic               w_carry_out_prox;
    logic               w_overflow_prox;

    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [3:0]         w_add_soma;
    logic               w_add_cout;

    // Current nibble of each latched operand.
    assign w_a_nib = 4'(r_a >> {r_idx, 2'b00});
    assign w_b_nib = 4'(r_b >> {r_idx, 2'b00});

    somador_4bits u_somador (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_soma (w_add_soma),
        .o_cout (w_add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    always_comb begin
        w_prox_estado    = r_estado;
        w_a_prox         = r_a;
        w_b_prox         = r_b;
        w_carry_prox     = r_carry;
        w_idx_prox       = r_idx;
        w_soma_prox      = r_soma;
        w_carry_out_prox = r_carry_out;
        w_overflow_prox  = r_overflow;

        case (r_estado)
            OCIOSO, CONCLUIDO: begin
                if (inicio) begin
                    w_a_prox      = a;
                    w_b_prox      = sub ? ~b : b;
                    w_carry_prox  = sub ? 1'b1 : cin;
                    w_idx_prox    = '0;
                    w_prox_estado = SOMANDO;
                end else begin
                    w_prox_estado = OCIOSO;
                end
            end
            SOMANDO: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (r_idx == IDX_W'(i)) begin
                        w_soma_prox[4*i +: 4] = w_add_soma;
                    end
                end
                w_carry_prox = w_add_cout;
                w_idx_prox   = IDX_W'(r_idx + 1'b1);
                if (r_idx == IDX_W'(NIBBLES - 1)) begin
                    // Sign rule uses the latched B, so subtraction sees ~b.
                    w_carry_out_prox = w_add_cout;
                    w_overflow_prox  = (r_a[W-1] == r_b[W-1]) && (w_add_soma[3] != r_a[W-1]);
                    w_idx_prox       = '0;
                    w_prox_estado    = CONCLUIDO;
                end
            end
            default: begin
                w_prox_estado = OCIOSO;
            end
        endcase
    end

    // Datapath and registered status flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_soma      <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_ocupado   <= 1'b0;
            r_pronto    <= 1'b0;
        end else begin
            r_a         <= w_a_prox;
            r_b         <= w_b_prox;
            r_carry     <= w_carry_prox;
            r_idx       <= w_idx_prox;
            r_soma      <= w_soma_prox;
            r_carry_out <= w_carry_out_prox;
            r_overflow  <= w_overflow_prox;
            r_ocupado   <= (w_prox_estado == SOMANDO);
            r_pronto    <= (w_prox_estado == CONCLUIDO);
        end
    end

    assign ocupado   = r_ocupado;
    assign pronto    = r_pronto;
    assign soma      = r_soma;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_controlador_soma_serial.sv
// Bench for controlador_soma_serial: arithmetic/timing model for a 4-nibble
// instance checked every cycle, plus literal checks including a 1-nibble instance.

module tb_controlador_soma_serial;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst, inicio, sub, cin;
    logic [15:0] a, b;
    logic        ocupado, pronto, carry_out, overflow;
    logic [15:0] soma;

    logic        inicio1, sub1, cin1;
    logic [3:0]  a1, b1;
    logic        ocupado1, pronto1, carry_out1, overflow1;
    logic [3:0]  soma1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controlador_soma_serial #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .inicio(inicio), .sub(sub), .cin(cin),
        .a(a), .b(b), .ocupado(ocupado), .pronto(pronto), .soma(soma),
        .carry_out(carry_out), .overflow(overflow)
    );

    controlador_soma_serial #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .inicio(inicio1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .ocupado(ocupado1), .pronto(pronto1), .soma(soma1),
        .carry_out(carry_out1), .overflow(overflow1)
    );

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Model: m_fase 0 = idle, 1..N = busy cycles, N+1 = result cycle.
    int          m_fase  = 0;
    bit          m_valid = 0;
    logic [15:0] m_soma, m_pend_soma, m_bb;
    logic        m_co, m_ov, m_pend_co, m_pend_ov;
    logic [16:0] m_full;

    always @(posedge clk) begin
        if (rst) begin
            m_fase  = 0;
            m_soma  = 16'h0;
            m_co    = 1'b0;
            m_ov    = 1'b0;
            m_valid = 1;
        end else if (m_valid) begin
            if (m_fase == 0 || m_fase == N + 1) begin
                if (inicio) begin
                    m_bb        = sub ? ~b : b;
                    m_full      = {1'b0, a} + {1'b0, m_bb} + 17'(sub ? 1'b1 : cin);
                    m_pend_soma = m_full[15:0];
                    m_pend_co   = m_full[16];
                    m_pend_ov   = (a[15] == m_bb[15]) && (m_full[15] != a[15]);
                    m_fase      = 1;
                end else begin
                    m_fase = 0;
                end
            end else begin
                m_fase++;
                if (m_fase == N + 1) begin
                    m_soma = m_pend_soma;
                    m_co   = m_pend_co;
                    m_ov   = m_pend_ov;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ocupado", 32'(ocupado), 32'(m_fase >= 1 && m_fase <= N));
            check("model_pronto",  32'(pronto),  32'(m_fase == N + 1));
            if (!(m_fase >= 1 && m_fase <= N)) begin
                check("model_soma",      32'(soma),      32'(m_soma));
                check("model_carry_out", 32'(carry_out), 32'(m_co));
                check("model_overflow",  32'(overflow),  32'(m_ov));
            end
        end
    end

    // One operation with literal expectations; returns after the pronto cycle.
    task automatic op(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                      input logic vc, input logic [15:0] es, input logic eco, input logic eov);
        int lat, busy;
        @(negedge clk);
        a = va; b = vb; sub = vs; cin = vc; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        lat  = 1;
        busy = 0;
        while (!pronto && lat < 20) begin
            if (ocupado) busy++;
            @(negedge clk);
            lat++;
        end
        check("lit_latency",   32'(lat),       32'(N + 1));
        check("lit_busy",      32'(busy),      32'(N));
        check("lit_soma",      32'(soma),      32'(es));
        check("lit_carry_out", 32'(carry_out), 32'(eco));
        check("lit_overflow",  32'(overflow),  32'(eov));
    endtask

    initial begin
        int lat;
        rst = 1'b1; inicio = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        inicio1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        check("rst_pronto",  32'(pronto),  32'd0);
        check("rst_soma",    32'(soma),    32'd0);
        check("rst1_soma",   32'(soma1),   32'd0);
        rst = 1'b0;

        op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        op(16'h0100, 16'h0023, 1'b0, 1'b1, 16'h0124, 1'b0, 1'b0);

        // Ignored request while busy, then back-to-back start on the pronto edge.
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; inicio = 1'b1;
        @(negedge clk);
        a = 16'hAAAA; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (2) @(negedge clk);
        a = 16'h0010; b = 16'h0020; inicio = 1'b1;
        @(negedge clk);
        check("b2b_pronto1", 32'(pronto), 32'd1);
        check("b2b_soma1",   32'(soma),   32'h0002);
        @(negedge clk);
        inicio = 1'b0;
        check("b2b_ocupado", 32'(ocupado), 32'd1);
        lat = 1;
        while (!pronto && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency", 32'(lat),  32'(N + 1));
        check("b2b_soma2",   32'(soma), 32'h0030);

        // Abort with reset mid-operation, then a clean operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ocupado", 32'(ocupado),   32'd0);
        check("abort_pronto",  32'(pronto),    32'd0);
        check("abort_soma",    32'(soma),      32'd0);
        check("abort_co",      32'(carry_out), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_pronto", 32'(pronto), 32'd0);
        end
        op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        // Single-nibble instance.
        @(negedge clk);
        a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; sub1 = 1'b0; inicio1 = 1'b1;
        @(negedge clk);
        inicio1 = 1'b0;
        check("n1_ocupado_c1", 32'(ocupado1), 32'd1);
        check("n1_pronto_c1",  32'(pronto1),  32'd0);
        @(negedge clk);
        check("n1_pronto_c2",  32'(pronto1),    32'd1);
        check("n1_soma",       32'(soma1),      32'h2);
        check("n1_carry_out",  32'(carry_out1), 32'd1);
        check("n1_overflow",   32'(overflow1),  32'd1);
        @(negedge clk);
        check("n1_pronto_c3",  32'(pronto1), 32'd0);
        check("n1_soma_hold",  32'(soma1),   32'h2);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
